status_mode_ctrl: RTL and testbench



---
 rtl/status_mode_ctrl.sv | 117 +++++++++++
 tb/tb_status_mode_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/status_mode_ctrl.sv
// status_mode_ctrl: merges busy level, error strobes and an ack button
// into the 2-bit indicator mode, with minimum hold times and latched errors.
module status_mode_ctrl #(
    parameter int MIN_HOLD   = 4_000_000,
    parameter int ERR_HOLD   = 50_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       busy_i,
    input  logic       err_i,
    input  logic       ack_btn,
    output logic [1:0] mode,
    output logic       err_active,
    output logic [3:0] err_count
);

    localparam int HOLD_MAX =
        (MIN_HOLD > ERR_HOLD) ? MIN_HOLD : ERR_HOLD;
    localparam int TW = $clog2(HOLD_MAX + 1);
    localparam int DW = $clog2(DEB_CYCLES + 1);

    localparam logic [TW-1:0] MIN_LD   = TW'(MIN_HOLD);
    localparam logic [TW-1:0] ERR_LD   = TW'(ERR_HOLD);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          ack_m;
    logic          ack_s;
    logic          deb;
    logic          deb_q;
    logic [DW-1:0] deb_cnt;
    logic          press;

    // Two-flop synchronizer, then a level debouncer on the synced button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_m   <= 1'b0;
            ack_s   <= 1'b0;
            deb     <= 1'b0;
            deb_q   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            ack_m <= ack_btn;
            ack_s <= ack_m;
            deb_q <= deb;
            if (ack_s != deb) begin
                if (deb_cnt == DEB_LAST) begin
                    deb     <= ack_s;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DW'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    assign press = deb & ~deb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            err_count <= 4'd0;
        end else begin
            if (timer != '0) begin
                timer <= timer - TW'(1);
            end
            if (err_i) begin
                state <= ERROR;
                timer <= ERR_LD;
                if (err_count != 4'hf) begin
                    err_count <= err_count + 4'd1;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        if (busy_i) begin
                            state <= BUSY;
                            timer <= MIN_LD;
                        end
                    end
                    BUSY: begin
                        if (timer == '0 && !busy_i) begin
                            state <= IDLE;
                        end
                    end
                    ERROR: begin
                        // Early presses are dropped, not remembered.
                        if (timer == '0 && press) begin
                            if (busy_i) begin
                                state <= BUSY;
                                timer <= MIN_LD;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign mode       = state;
    assign err_active = (state == ERROR);

endmodule

// File: tb/tb_status_mode_ctrl.sv
// tb_status_mode_ctrl: directed stimulus with a cycle-tagged scoreboard
// drained by a negedge monitor.
module tb_status_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy_i = 1'b0;
    logic       err_i = 1'b0;
    logic       ack_btn = 1'b0;
    logic [1:0] mode;
    logic       err_active;
    logic [3:0] err_count;

    always #5 clk = ~clk;

    status_mode_ctrl #(
        .MIN_HOLD  (4),
        .ERR_HOLD  (8),
        .DEB_CYCLES(3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .busy_i    (busy_i),
        .err_i     (err_i),
        .ack_btn   (ack_btn),
        .mode      (mode),
        .err_active(err_active),
        .err_count (err_count)
    );

    typedef struct {
        int         cyc;
        logic [1:0] m;
        logic       ea;
        logic [3:0] c;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL stale: entry for cycle %0d unchecked at %0d",
                         e.cyc, cyc);
            end else if (mode !== e.m || err_active !== e.ea ||
                         err_count !== e.c) begin
                errors++;
                $display("FAIL cyc%0d: got mode=%0d ea=%0b cnt=%0d, want mode=%0d ea=%0b cnt=%0d",
                         cyc, mode, err_active, err_count,
                         e.m, e.ea, e.c);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input logic [1:0] m, input logic ea,
                              input logic [3:0] c);
        exp_t e;
        e.cyc = cyc;
        e.m   = m;
        e.ea  = ea;
        e.c   = c;
        q.push_back(e);
    endtask

    task automatic step(input logic [1:0] m, input logic ea,
                        input logic [3:0] c);
        tick();
        expect_now(m, ea, c);
    endtask

    task automatic run(input int n, input logic [1:0] m, input logic ea,
                       input logic [3:0] c);
        for (int i = 0; i < n; i++) step(m, ea, c);
    endtask

    initial begin
        // reset state
        run(3, 2'd0, 1'b0, 4'd0);
        rst_n = 1'b1;
        run(9, 2'd0, 1'b0, 4'd0);

        // one-cycle busy pulse held for MIN_HOLD+1 cycles
        busy_i = 1'b1;
        step(2'd1, 1'b0, 4'd0);
        busy_i = 1'b0;
        run(4, 2'd1, 1'b0, 4'd0);
        step(2'd0, 1'b0, 4'd0);
        run(2, 2'd0, 1'b0, 4'd0);

        // error beats busy; further errors restart the hold
        busy_i = 1'b1;
        err_i  = 1'b1;
        step(2'd2, 1'b1, 4'd1);
        err_i  = 1'b0;
        busy_i = 1'b0;
        run(2, 2'd2, 1'b1, 4'd1);
        err_i = 1'b1;
        step(2'd2, 1'b1, 4'd2);
        err_i = 1'b0;
        run(2, 2'd2, 1'b1, 4'd2);
        err_i = 1'b1;
        step(2'd2, 1'b1, 4'd3);
        err_i = 1'b0;

        // early press discarded, later press exits to IDLE
        step(2'd2, 1'b1, 4'd3);
        ack_btn = 1'b1;
        run(3, 2'd2, 1'b1, 4'd3);
        ack_btn = 1'b0;
        run(4, 2'd2, 1'b1, 4'd3);
        ack_btn = 1'b1;
        run(5, 2'd2, 1'b1, 4'd3);
        step(2'd0, 1'b0, 4'd3);
        ack_btn = 1'b0;
        run(6, 2'd0, 1'b0, 4'd3);

        // exit with busy high goes to BUSY
        err_i = 1'b1;
        step(2'd2, 1'b1, 4'd4);
        err_i = 1'b0;
        run(8, 2'd2, 1'b1, 4'd4);
        ack_btn = 1'b1;
        run(4, 2'd2, 1'b1, 4'd4);
        busy_i = 1'b1;
        step(2'd2, 1'b1, 4'd4);
        step(2'd1, 1'b0, 4'd4);
        busy_i  = 1'b0;
        ack_btn = 1'b0;
        run(4, 2'd1, 1'b0, 4'd4);
        step(2'd0, 1'b0, 4'd4);
        run(3, 2'd0, 1'b0, 4'd4);

        // bouncing button gives no press; a stable one does
        err_i = 1'b1;
        step(2'd2, 1'b1, 4'd5);
        err_i = 1'b0;
        run(9, 2'd2, 1'b1, 4'd5);
        for (int i = 0; i < 20; i++) begin
            ack_btn = ((i % 4) < 2);
            step(2'd2, 1'b1, 4'd5);
        end
        ack_btn = 1'b1;
        run(5, 2'd2, 1'b1, 4'd5);
        step(2'd0, 1'b0, 4'd5);
        ack_btn = 1'b0;

        // error counter saturation
        err_i = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step(2'd2, 1'b1, (5 + k > 15) ? 4'd15 : 4'(5 + k));
        end
        err_i = 1'b0;

        // async reset mid-ERROR with timer at 5
        run(2, 2'd2, 1'b1, 4'd15);
        tick();
        rst_n = 1'b0;
        expect_now(2'd0, 1'b0, 4'd0);
        run(2, 2'd0, 1'b0, 4'd0);
        rst_n = 1'b1;
        run(5, 2'd0, 1'b0, 4'd0);

        tick();
        tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
